// File: rtl/adder_arb_pkg.sv
// Shared constants, types and the round-robin pick function for the adder arbiter.
package adder_arb_pkg;

  localparam int unsigned OPND_W  = 8;
  localparam int unsigned SUM_W   = 9;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of elig at or after ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] elig,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k < n && !p.found && elig[cand[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// Single-stage registered 8+8 unsigned adder with a valid pipeline bit.
module adder_8bit
  import adder_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic              data_in_vld,
  output logic [SUM_W-1:0]  data_out,
  output logic              data_out_vld
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else begin
      data_out     <= {1'b0, a} + {1'b0, b};
      data_out_vld <= data_in_vld;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over elig, with the rotating priority pointer.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned TAG_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     elig,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  output logic [TAG_W-1:0] gnt_idx
);

  logic [TAG_W-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] elig_ext;
  pick_t              pick;

  always_comb begin
    elig_ext        = '0;
    elig_ext[N-1:0] = elig;
    pick            = rr_pick(elig_ext, IDX_W'(ptr_q), N);
    // No grants may leave while reset is held.
    gnt_vld         = pick.found & rst_n;
    gnt_idx         = pick.idx[TAG_W-1:0];
    gnt             = '0;
    ptr_d           = ptr_q;
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == TAG_W'(N - 1)) ? '0 : gnt_idx + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder_8bit among N_REQ requesters: round-robin grant, tag, and
// per-requester result slots with valid/ready responses.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned TAG_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_vld,
  output logic [N_REQ-1:0]         req_rdy,
  input  logic [N_REQ*OPND_W-1:0]  req_a,
  input  logic [N_REQ*OPND_W-1:0]  req_b,
  output logic [N_REQ-1:0]         rsp_vld,
  input  logic [N_REQ-1:0]         rsp_rdy,
  output logic [N_REQ*SUM_W-1:0]   rsp_data
);

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  inflight_q, inflight_d;
  logic [N_REQ-1:0]  slot_full_q, slot_full_d;
  logic [SUM_W-1:0]  slot_q [N_REQ];
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic [OPND_W-1:0] add_a, add_b;
  logic [SUM_W-1:0]  sum;
  logic              sum_vld;

  // Registered state only, so a slot consumed this cycle cannot be re-granted until next.
  assign elig = req_vld & ~inflight_q & ~slot_full_q;

  rr_arbiter #(
    .N     (N_REQ),
    .TAG_W (TAG_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig    (elig),
    .gnt     (req_rdy),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign add_a = req_a[32'(gnt_idx)*OPND_W +: OPND_W];
  assign add_b = req_b[32'(gnt_idx)*OPND_W +: OPND_W];

  adder_8bit u_add (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (add_a),
    .b            (add_b),
    .data_in_vld  (gnt_vld),
    .data_out     (sum),
    .data_out_vld (sum_vld)
  );

  // Landing and consumption never target the same slot, so plain set/clear order is safe.
  always_comb begin
    inflight_d  = inflight_q | req_rdy;
    slot_full_d = slot_full_q & ~rsp_rdy;
    if (sum_vld) begin
      inflight_d[tag_q]  = 1'b0;
      slot_full_d[tag_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q  <= '0;
      slot_full_q <= '0;
      tag_q       <= '0;
      slot_q      <= '{default: '0};
    end else begin
      inflight_q  <= inflight_d;
      slot_full_q <= slot_full_d;
      if (gnt_vld) tag_q <= gnt_idx;
      if (sum_vld) slot_q[tag_q] <= sum;
    end
  end

  assign rsp_vld = slot_full_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
    assign rsp_data[i*SUM_W +: SUM_W] = slot_q[i];
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed requests push expected sums,
// a monitor pops and compares on every response handshake.
module tb_adder_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [N*8-1:0] req_a, req_b;
  logic [N*9-1:0] rsp_data;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_q [N][$];

  always #5 clk = ~clk;

  adder_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_data (rsp_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic issue(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
    req_vld[i]      = 1'b1;
    exp_q[i].push_back(a + b);
  endtask

  // One clock: optional directed check of grant/response vectors, then drop transferred requests.
  task automatic tick(input string name, input bit chk, input logic [N-1:0] exp_rdy,
                      input logic [N-1:0] exp_rsp);
    logic [N-1:0] xfer;
    @(negedge clk);
    if (chk) begin
      check({name, ".req_rdy"}, 32'(req_rdy), 32'(exp_rdy));
      check({name, ".rsp_vld"}, 32'(rsp_vld), 32'(exp_rsp));
    end
    xfer = req_vld & req_rdy;
    @(posedge clk);
    #1;
    req_vld &= ~xfer;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic do_reset(input logic [N-1:0] vld_during);
    rst_n   = 1'b0;
    req_vld = vld_during;
    flush();
    @(negedge clk);
    check("reset.req_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    req_vld = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_vld[i] && rsp_rdy[i]) begin
          if (exp_q[i].size() == 0)
            check($sformatf("rsp%0d.unexpected", i), 32'd1, 32'd0);
          else
            check($sformatf("rsp%0d.data", i), 32'(rsp_data[i*9 +: 9]),
                  exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    req_a   = '0;
    req_b   = '0;
    rsp_rdy = '1;
    @(posedge clk);
    #1;
    do_reset(4'b1111);
    tick("post_reset", 1, 4'b0000, 4'b0000);
    check("post_reset.rsp_data", 32'(rsp_data), 32'd0);

    // Single request: 200+100 = 300, visible two cycles after grant.
    issue(0, 200, 100);
    tick("single.t0", 1, 4'b0001, 4'b0000);
    tick("single.t1", 1, 4'b0000, 4'b0000);
    tick("single.t2", 1, 4'b0000, 4'b0001);
    tick("single.t3", 1, 4'b0000, 4'b0000);

    // All four at once after reset: grants 0..3, sums 0, 11, 22, 33.
    do_reset(4'b0000);
    for (int i = 0; i < N; i++) issue(i, i, 10 * i);
    tick("all.t0", 1, 4'b0001, 4'b0000);
    tick("all.t1", 1, 4'b0010, 4'b0000);
    tick("all.t2", 1, 4'b0100, 4'b0001);
    tick("all.t3", 1, 4'b1000, 4'b0010);
    tick("all.t4", 1, 4'b0000, 4'b0100);
    tick("all.t5", 1, 4'b0000, 4'b1000);
    tick("all.t6", 1, 4'b0000, 4'b0000);

    // Rotation: after a grant to 2, both 0 and 3 waiting -> 3 first, then 0.
    issue(2, 5, 6);
    tick("rot.t0", 1, 4'b0100, 4'b0000);
    issue(0, 1, 2);
    issue(3, 7, 8);
    tick("rot.t1", 1, 4'b1000, 4'b0000);
    tick("rot.t2", 1, 4'b0001, 4'b0100);
    tick("rot.t3", 1, 4'b0000, 4'b1000);
    tick("rot.t4", 1, 4'b0000, 4'b0001);
    tick("rot.t5", 1, 4'b0000, 4'b0000);

    // Backpressure on requester 1 with a 255+255 result.
    rsp_rdy = 4'b1101;
    issue(1, 255, 255);
    tick("bp.t0", 1, 4'b0010, 4'b0000);
    tick("bp.t1", 1, 4'b0000, 4'b0000);
    tick("bp.t2", 1, 4'b0000, 4'b0010);
    check("bp.hold0", 32'(rsp_data[9 +: 9]), 32'd510);
    issue(1, 1, 1);
    issue(0, 9, 9);
    issue(2, 20, 30);
    tick("bp.u0", 1, 4'b0100, 4'b0010);
    tick("bp.u1", 1, 4'b0001, 4'b0010);
    tick("bp.u2", 1, 4'b0000, 4'b0110);
    tick("bp.u3", 1, 4'b0000, 4'b0011);
    tick("bp.u4", 1, 4'b0000, 4'b0010);
    check("bp.hold1", 32'(rsp_data[9 +: 9]), 32'd510);
    rsp_rdy = 4'b1111;
    tick("bp.v0", 1, 4'b0000, 4'b0010);
    tick("bp.v1", 1, 4'b0010, 4'b0000);
    tick("bp.v2", 1, 4'b0000, 4'b0000);
    tick("bp.v3", 1, 4'b0000, 4'b0010);
    tick("bp.v4", 1, 4'b0000, 4'b0000);

    // Reset while requester 3's sum is in the adder: it must never surface.
    issue(3, 3, 4);
    tick("rmid.t0", 1, 4'b1000, 4'b0000);
    rst_n = 1'b0;
    flush();
    tick("rmid.t1", 1, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    tick("rmid.t2", 1, 4'b0000, 4'b0000);
    tick("rmid.t3", 1, 4'b0000, 4'b0000);
    tick("rmid.t4", 1, 4'b0000, 4'b0000);
    for (int i = 0; i < N; i++) issue(i, 10 + i, 20);
    tick("rmid.g0", 1, 4'b0001, 4'b0000);
    tick("rmid.g1", 1, 4'b0010, 4'b0000);
    tick("rmid.g2", 1, 4'b0100, 4'b0001);
    tick("rmid.g3", 1, 4'b1000, 4'b0010);
    tick("rmid.g4", 1, 4'b0000, 4'b0100);
    tick("rmid.g5", 1, 4'b0000, 4'b1000);
    tick("rmid.g6", 1, 4'b0000, 4'b0000);

    for (int i = 0; i < N; i++)
      check($sformatf("q%0d.drained", i), 32'(exp_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one `adder_8bit` instance among `N_REQ` independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants at most one request per cycle, tags it, and routes the 9-bit sum back to the originating requester. It sits between the requester front-ends and the shared adder datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TAG_W`, default `$clog2(N_REQ)`: requester index width. Derived; not overridden.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Synchronous, active-low, one clock.
- `req_vld`  in  `N_REQ`  request valid, one bit per requester.
- `req_rdy`  out  `N_REQ`  request accepted this cycle. One-hot or zero.
- `req_a`  in  `N_REQ*8`  operand A; requester i occupies bits `[8i+7:8i]`.
- `req_b`  in  `N_REQ*8`  operand B; same packing as `req_a`.
- `rsp_vld`  out  `N_REQ`  response valid, per requester.
- `rsp_rdy`  in  `N_REQ`  response consumed, per requester.
- `rsp_data`  out  `N_REQ*9`  sum; requester i occupies bits `[9i+8:9i]`.

## Operation
- **Per-requester state:**
  - `inflight[i]`: granted, result not yet landed.
  - `slot_full[i]`: result held, drives `rsp_vld[i]`.
- **Eligibility:** `elig[i] = req_vld[i] & ~inflight[i] & ~slot_full[i]`. Each requester has at most one transaction outstanding.
- **Arbitration:** round-robin over `elig`, combinational.
  - Search starts at `ptr` and wraps from `N_REQ-1` to 0.
  - The winner g gets `req_rdy[g]=1`. No winner means `req_rdy=0`.
  - On a grant, `ptr <= g+1` (mod `N_REQ`). With no grant, `ptr` holds.
- **Handshake rules:**
  - Transfer occurs when `req_vld[i] & req_rdy[i]`.
  - `req_rdy` depends on `req_vld`. Requesters must not make `req_vld` depend on `req_rdy`.
  - Once asserted, `req_vld` and the operands must stay stable until transfer.
- **Datapath:**
  - Adder inputs are muxed from the granted requester: `data_in_vld = |req_rdy`.
  - Grant index g is registered into `tag_q` alongside the adder's pipeline stage.
- **Result landing:**
  - When adder `data_out_vld` is high, `slot[tag_q] <= data_out` and `slot_full[tag_q] <= 1`.
  - In the same edge, `inflight[tag_q] <= 0`.
- **Response:**
  - `rsp_vld[i] = slot_full[i]`; `rsp_data[i] = slot[i]`.
  - `slot_full[i]` clears on `rsp_vld[i] & rsp_rdy[i]`.
  - `rsp_data[i]` holds stable while `rsp_vld[i]` is high.
- **Arithmetic:** unsigned 8+8, zero-extended to 9 bits. No overflow is possible (max 510).
- **Simultaneous events:**
  - Landing into slot j and consuming slot k in the same cycle (j≠k) are independent.
  - j=k cannot occur, because a slot cannot be full while its own request is inflight.
  - A grant to requester i in the same cycle its slot is consumed is not allowed: eligibility uses the registered `slot_full`.
- **Reset (`rst_n` low at a clock edge):**
  - `ptr=0`, `inflight=0`, `slot_full=0`, `tag_q=0`, `slot=0`.
  - `req_rdy` is forced to 0 while `rst_n` is low.
  - The adder's `rst_n` is tied to the same signal.
  - Reset mid-operation discards in-flight and held results; no responses appear afterward.

## Timing
- Reset values: `req_rdy=0`, `rsp_vld=0`, `rsp_data=0`.
- Latency: grant in cycle t → adder output in cycle t+1 → `rsp_vld` high in cycle t+2, provided `rsp_rdy` arrives as needed.
- Aggregate throughput: one grant per cycle.
- Per-requester maximum rate: one request per 3 cycles with `rsp_rdy` held high (grant t, land t+1, respond t+2, consume t+2, re-grant t+3).
- Fairness: a continuously eligible requester is granted within `N_REQ` cycles.

## Structure
- **Package `adder_arb_pkg`:**
  - `OPND_W=8`, `SUM_W=9`.
  - Function `rr_pick(elig, ptr)` returning the grant index and a found flag.
- **Sub-module `rr_arbiter`** (parameter `N`): combinational pick plus the `ptr` register.
- **Top level:** instantiates `rr_arbiter` and `adder_8bit`, plus the tag register, `inflight`/`slot_full` vectors and the slot array.
- Target size: about 150–250 lines of RTL.

## Test plan
- **Single request:** requester 0 sends A=200, B=100 in cycle t → `req_rdy[0]` high in t; `rsp_vld[0]` high in t+2 with `rsp_data[0]=300` (9'h12C); other `rsp_vld` stay 0.
- **All requesting after reset:** all four raise `req_vld` in the same cycle, operands A=i, B=10i → grants to 0, 1, 2, 3 in consecutive cycles; responses 0, 11, 22, 33 appear on their own channels in that order, each 2 cycles after its grant.
- **Rotation:** after a grant to requester 2, requesters 0 and 3 both eligible → next grant goes to 3, then 0.
- **Backpressure:** requester 1 sends 255+255 with `rsp_rdy[1]=0` → `rsp_vld[1]` holds with 510 (9'h1FE) indefinitely; a new `req_vld[1]` is not granted until `rsp_rdy[1]` is pulsed. Other requesters continue to be served.
- **Reset mid-flight:** grant to requester 3 in cycle t, `rst_n` low in t+1 → no `rsp_vld` ever appears for it; `ptr=0` afterward, so the next simultaneous request set grants requester 0 first.
